// File: rtl/fvlv_pkg.sv
// fvlv_pkg: shared decoder state encoding, counter widths and helpers.
package fvlv_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        FRAME     = 2'd2,
        LINE      = 2'd3
    } dec_state_t;

    localparam int PIX_CNT_W   = 12;
    localparam int LINE_CNT_W  = 11;
    localparam int FRAME_CNT_W = 16;
    localparam int PULSE_W     = 8;

    typedef logic [PIX_CNT_W-1:0]   pix_cnt_t;
    typedef logic [LINE_CNT_W-1:0]  line_cnt_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;
    typedef logic [PULSE_W-1:0]     pulse_len_t;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    function automatic pix_cnt_t pix_sat_inc(input pix_cnt_t c);
        return (c == '1) ? c : c + pix_cnt_t'(1);
    endfunction

    function automatic line_cnt_t line_sat_inc(input line_cnt_t c);
        return (c == '1) ? c : c + line_cnt_t'(1);
    endfunction

endpackage

// File: rtl/fvlv_sync_decoder_pulse_stretch.sv
// pulse_stretch: turns a one-cycle load strobe into a pulse of 'length' cycles.
// A load while the pulse is running restarts the count from the new load.
module pulse_stretch
    import fvlv_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       load,
    input  pulse_len_t length,
    output logic       pulse
);

    pulse_len_t cnt;

    // Remaining pulse cycles; reload wins over the countdown.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= length;
        end else if (cnt != '0) begin
            cnt <= cnt - pulse_len_t'(1);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/fvlv_sync_decoder.sv
// fvlv_sync_decoder: decodes frame-valid / line-valid camera timing into
// regenerated vsync/hsync, a data enable with aligned data, and line/frame
// length checks plus a completed-frame counter.
module fvlv_sync_decoder
    import fvlv_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int HSYNC_W  = 40,
    parameter int VSYNC_W  = 5
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   fv_i,
    input  logic                   lv_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   vsync_o,
    output logic                   hsync_o,
    output logic                   de_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   line_err_o,
    output logic                   frame_err_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    logic              fv_r, lv_r, fv_d, lv_d, in_valid;
    logic [DATA_W-1:0] data_r;
    dec_state_t        state, state_nxt;
    pix_cnt_t          pix_cnt;
    line_cnt_t         line_cnt, line_cnt_eff;
    frame_cnt_t        frame_cnt_q;
    logic              fv_rise, fv_fall, lv_rise, lv_fall;
    logic              frame_start, frame_end, line_start, line_end, de_nxt;

    // Register the raw inputs once; a second copy feeds the edge detectors.
    // in_valid marks that the input registers hold real samples after reset,
    // so a still-high fv is not mistaken for the idle gap.
    always_ff @(posedge sys_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!sys_rst) begin
            fv_r     <= 1'b0;
            lv_r     <= 1'b0;
            // NOTE: the data pipeline is reset as well, since data_o must read
            // zero out of reset and data_r feeds it directly.
            data_r   <= '0;
            fv_d     <= 1'b0;
            lv_d     <= 1'b0;
            in_valid <= 1'b0;
        end else begin
            fv_r     <= fv_i;
            lv_r     <= lv_i;
            data_r   <= data_i;
            fv_d     <= fv_r;
            lv_d     <= lv_r;
            in_valid <= 1'b1;
        end
    end

    assign fv_rise = fv_r & ~fv_d;
    assign fv_fall = ~fv_r & fv_d;
    assign lv_rise = lv_r & ~lv_d;
    assign lv_fall = ~lv_r & lv_d;

    // A falling fv inside a line also terminates that line.
    assign frame_start  = (state == IDLE) && fv_rise;
    assign frame_end    = ((state == FRAME) || (state == LINE)) && fv_fall;
    assign line_start   = (state == FRAME) && fv_r && lv_rise;
    assign line_end     = (state == LINE) && (lv_fall || fv_fall);
    assign de_nxt       = fv_r && lv_r && ((state == LINE) || line_start);
    assign line_cnt_eff = line_end ? line_sat_inc(line_cnt) : line_cnt;

    // Decoder state register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) state <= WAIT_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode from the registered fv/lv edges.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (in_valid && !fv_r) state_nxt = IDLE;
            IDLE:      if (frame_start)       state_nxt = FRAME;
            FRAME:     if (fv_fall)           state_nxt = IDLE;
                       else if (line_start)   state_nxt = LINE;
            LINE:      if (fv_fall)           state_nxt = IDLE;
                       else if (lv_fall)      state_nxt = FRAME;
            default:                          state_nxt = WAIT_IDLE;
        endcase
    end

    // Pixel, line and frame counters. The line-start cycle is itself a
    // pixel, so the pixel count restarts at one rather than zero.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (line_start)  pix_cnt <= pix_cnt_t'(1);
            else if (de_nxt) pix_cnt <= pix_sat_inc(pix_cnt);

            if (frame_start) line_cnt <= '0;
            else             line_cnt <= line_cnt_eff;

            if (frame_end) frame_cnt_q <= frame_cnt_q + frame_cnt_t'(1);
        end
    end

    // Registered data enable, aligned data and one-cycle error strobes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            de_o        <= 1'b0;
            data_o      <= '0;
            line_err_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            de_o        <= de_nxt;
            data_o      <= de_nxt ? data_r : '0;
            line_err_o  <= line_end && (pix_cnt != pix_cnt_t'(H_ACTIVE));
            frame_err_o <= frame_end && (line_cnt_eff != line_cnt_t'(V_ACTIVE));
        end
    end

    assign frame_cnt_o = frame_cnt_q;

    pulse_stretch u_hsync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (line_end),
        .length  (pulse_len_t'(HSYNC_W)),
        .pulse   (hsync_o)
    );

    pulse_stretch u_vsync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (frame_start),
        .length  (pulse_len_t'(VSYNC_W)),
        .pulse   (vsync_o)
    );

endmodule

// File: tb/tb_fvlv_sync_decoder.sv
// tb_fvlv_sync_decoder: scoreboard bench. A stimulus plan is built first, a
// reference model derives the expected output of every cycle from frame and
// line intervals, the driver pushes each cycle's expectation as it applies
// the inputs, and a negedge monitor pops and compares.
module tb_fvlv_sync_decoder;

    localparam int DATA_W   = 8;
    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 2;
    localparam int HSYNC_W  = 3;
    localparam int VSYNC_W  = 2;
    localparam int NMAX     = 4000;
    localparam int NEXP     = NMAX + 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              fv_i    = 1'b0;
    logic              lv_i    = 1'b0;
    logic [DATA_W-1:0] data_i  = '0;
    logic              vsync_o, hsync_o, de_o, line_err_o, frame_err_o;
    logic [DATA_W-1:0] data_o;
    logic [15:0]       frame_cnt_o;

    fvlv_sync_decoder #(
        .DATA_W   (DATA_W),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .HSYNC_W  (HSYNC_W),
        .VSYNC_W  (VSYNC_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .fv_i        (fv_i),
        .lv_i        (lv_i),
        .data_i      (data_i),
        .vsync_o     (vsync_o),
        .hsync_o     (hsync_o),
        .de_o        (de_o),
        .data_o      (data_o),
        .line_err_o  (line_err_o),
        .frame_err_o (frame_err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [7:0]  data;
        logic        le;
        logic        fe;
        logic [15:0] fc;
    } obs_t;

    obs_t exp_q[$];
    int   cyc_q[$];
    int   total = 0;
    int   bad   = 0;

    // Stimulus plan, indexed by cycle.
    bit         fv_s[NMAX];
    bit         lv_s[NMAX];
    bit         rst_s[NMAX];
    bit         pre_s[NMAX];
    logic [7:0] dat_s[NMAX];
    int         np = 0;

    // Expected outputs, indexed by cycle.
    obs_t exp_a[NEXP];

    // Reference model state.
    int m_pix;
    int m_lines;
    bit m_in_line;

    task automatic put(input bit fv, input bit lv, input logic [7:0] d,
                       input bit rst = 1'b0, input bit pre = 1'b0);
        if (np < NMAX - 32) begin
            fv_s[np]  = fv;
            lv_s[np]  = lv;
            dat_s[np] = d;
            rst_s[np] = rst;
            pre_s[np] = pre;
            np++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic gap(input int n);
        repeat (n) put(1'b1, 1'b0, 8'h00);
    endtask

    task automatic line(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) put(1'b1, 1'b1, 8'(base + 8'(i)));
    endtask

    task automatic clean_frame(input logic [7:0] b0, input logic [7:0] b1);
        put(1'b1, 1'b0, 8'h00);
        gap(1);
        line(4, b0);
        gap(2);
        line(4, b1);
        gap(2);
        idle(4);
    endtask

    task automatic set_fc(input int from, input logic [15:0] v);
        for (int u = from; u < NEXP; u++) exp_a[u].fc = v;
    endtask

    // A line whose last valid pixel is cycle e: hsync on e+3..e+2+HSYNC_W
    // (overlapping pulses merge), length error flagged at e+3.
    task automatic end_line(input int e);
        for (int u = e + 3; u <= e + 2 + HSYNC_W; u++)
            if (u < NEXP) exp_a[u].hs = 1'b1;
        if (m_pix != H_ACTIVE && e + 3 < NEXP) exp_a[e + 3].le = 1'b1;
        if (m_lines < 2047) m_lines++;
        m_in_line = 1'b0;
    endtask

    task automatic pixel(input int t);
        if (m_pix < 4095) m_pix++;
        if (t + 2 < NEXP) begin
            exp_a[t + 2].de   = 1'b1;
            exp_a[t + 2].data = dat_s[t];
        end
    endtask

    // Walks the plan as frames and lines: frames open on an fv rise once fv
    // was seen low after reset, lines open on an lv rise inside a frame and
    // close on lv or fv going low; reset wipes everything scheduled later.
    task automatic run_model();
        bit          armed     = 1'b0;
        bit          in_frame  = 1'b0;
        int          wait_from = 0;
        logic [15:0] fcnt      = 16'h0000;
        for (int u = 0; u < NEXP; u++) exp_a[u] = '0;
        m_in_line = 1'b0;
        m_pix     = 0;
        m_lines   = 0;
        for (int t = 0; t < np; t++) begin
            if (rst_s[t]) begin
                for (int u = t + 1; u < NEXP; u++) exp_a[u] = '0;
                armed     = 1'b0;
                in_frame  = 1'b0;
                m_in_line = 1'b0;
                fcnt      = 16'h0000;
                wait_from = t + 1;
                continue;
            end
            if (pre_s[t]) begin
                fcnt = 16'hFFFE;
                set_fc(t, fcnt);
            end
            if (!armed) begin
                if (t >= wait_from && !fv_s[t]) armed = 1'b1;
                continue;
            end
            if (!in_frame) begin
                if (t > 0 && fv_s[t] && !fv_s[t - 1]) begin
                    in_frame = 1'b1;
                    m_lines  = 0;
                    for (int u = t + 2; u <= t + 1 + VSYNC_W; u++) exp_a[u].vs = 1'b1;
                end
                continue;
            end
            if (!fv_s[t]) begin
                if (m_in_line) end_line(t - 1);
                exp_a[t + 2].fe = (m_lines != V_ACTIVE);
                fcnt = fcnt + 16'h0001;
                set_fc(t + 2, fcnt);
                in_frame = 1'b0;
                continue;
            end
            if (m_in_line) begin
                if (lv_s[t]) pixel(t);
                else         end_line(t - 1);
            end else if (lv_s[t] && !lv_s[t - 1]) begin
                m_in_line = 1'b1;
                m_pix     = 0;
                pixel(t);
            end
        end
    endtask

    task automatic check(input string name, input int cyc,
                         input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge sys_clk) begin
        obs_t e;
        int   c;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("vsync",     c, {15'd0, vsync_o},     {15'd0, e.vs});
            check("hsync",     c, {15'd0, hsync_o},     {15'd0, e.hs});
            check("de",        c, {15'd0, de_o},        {15'd0, e.de});
            check("data",      c, {8'd0, data_o},       {8'd0, e.data});
            check("line_err",  c, {15'd0, line_err_o},  {15'd0, e.le});
            check("frame_err", c, {15'd0, frame_err_o}, {15'd0, e.fe});
            check("frame_cnt", c, frame_cnt_o,          e.fc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        int len;
        int kind;

        // Reset, then nominal frame with fv rising at cycle 10.
        put(1'b0, 1'b0, 8'h00, 1'b1);
        put(1'b0, 1'b0, 8'h00, 1'b1);
        idle(8);
        clean_frame(8'hA1, 8'hB1);

        // Short line (3) and long line (5).
        put(1'b1, 1'b0, 8'h00); gap(1);
        line(3, 8'h10); gap(2); line(5, 8'h20); gap(2); idle(5);

        // Three-line frame.
        put(1'b1, 1'b0, 8'h00); gap(1);
        line(4, 8'h30); gap(1); line(4, 8'h40); gap(1); line(4, 8'h50); gap(1); idle(5);

        // fv and lv fall together on line 2.
        put(1'b1, 1'b0, 8'h00); gap(1);
        line(4, 8'h60); gap(2); line(4, 8'h70); idle(6);

        // fv falls mid-line while lv stays high for two more cycles.
        put(1'b1, 1'b0, 8'h00); gap(1);
        line(4, 8'h80); gap(2); line(2, 8'h90);
        put(1'b0, 1'b1, 8'h92); put(1'b0, 1'b1, 8'h93); idle(5);

        // Back-to-back one-pixel lines: hsync reloads before expiring.
        put(1'b1, 1'b0, 8'h00); gap(1);
        line(1, 8'hC0); gap(1); line(1, 8'hC1); gap(1); line(1, 8'hC2); gap(4); idle(5);

        // One-cycle reset in the middle of line 1 with fv held high.
        idle(3);
        put(1'b1, 1'b0, 8'h00); gap(1);
        put(1'b1, 1'b1, 8'hD1); put(1'b1, 1'b1, 8'hD2, 1'b1);
        put(1'b1, 1'b1, 8'hD3); put(1'b1, 1'b1, 8'hD4);
        gap(2); line(4, 8'hD5); gap(2); idle(4);
        clean_frame(8'hE1, 8'hF1);

        // lv pulses with fv low, then frame counter preset and wrap.
        put(1'b0, 1'b1, 8'h55); idle(1); put(1'b0, 1'b1, 8'h66); put(1'b0, 1'b1, 8'h67); idle(2);
        put(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);
        clean_frame(8'h01, 8'h11);
        clean_frame(8'h21, 8'h31);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            idle(int'($urandom_range(4, 1)));
            put(1'b1, 1'b0, 8'h00);
            gap(int'($urandom_range(3, 1)));
            nl = int'($urandom_range(3, 1));
            for (int l = 0; l < nl; l++) begin
                len = int'($urandom_range(5, 1));
                if ($urandom_range(15, 0) == 0) begin
                    put(1'b1, 1'b1, 8'($urandom));
                    put(1'b1, 1'b1, 8'($urandom), 1'b1);
                end
                line(len, 8'($urandom));
                if (l == nl - 1) begin
                    kind = int'($urandom_range(2, 0));
                    if (kind == 0) begin
                        gap(int'($urandom_range(3, 1)));
                    end else if (kind == 2) begin
                        put(1'b0, 1'b1, 8'($urandom));
                    end
                end else begin
                    gap(int'($urandom_range(3, 1)));
                end
            end
            idle(int'($urandom_range(3, 1)));
        end
        idle(20);

        run_model();

        for (int t = 0; t < np; t++) begin
            @(posedge sys_clk);
            #1;
            sys_rst = ~rst_s[t];
            fv_i    = fv_s[t];
            lv_i    = lv_s[t];
            data_i  = dat_s[t];
            if (t > 0 && pre_s[t - 1]) release dut.frame_cnt_q;
            if (pre_s[t]) force dut.frame_cnt_q = 16'hFFFE;
            exp_q.push_back(exp_a[t]);
            cyc_q.push_back(t);
        end

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge sys_clk);
        @(posedge sys_clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
